nes_button_events: RTL and testbench
====================================

# nes_button_events

Converts the raw 8-bit NES button bytes produced by the controller shift interface into a debounced button state and a queue of press/release events. It sits directly downstream of the controller block. It takes each completed byte as a one-cycle `sample_valid` strobe, filters the bytes, detects edges, and serialises per-button events into an 8-deep FIFO. The CPU drains the FIFO over APB3 and can be interrupted when it is non-empty.

## Interface
- `DEBOUNCE_SAMPLES`, default 3: consecutive identical raw samples required before the debounced state updates; range 1..15.
- `FIFO_DEPTH`, default 8: event FIFO depth; must be a power of two, range 2..16.

Ports (name, direction, width, meaning):
- `PCLK`, in, 1: the single clock.
- `PRESET`, in, 1: synchronous, active-high reset.
- `sample`, in, 8: raw controller byte. Active-low, as shifted out of the pad (bit 7 = A … bit 0 = Right).
- `sample_valid`, in, 1: one-cycle strobe; `sample` is valid in that cycle.
- `PSEL`, `PENABLE`, `PWRITE`, in, 1 each: APB3 control.
- `PADDR`, in, 8: register address.
- `PWDATA`, in, 32: write data.
- `PRDATA`, out, 32: read data, combinational from registered state.
- `PREADY`, out, 1: tied to 1.
- `PSLVERR`, out, 1: tied to 0.
- `irq`, out, 1: registered; high when `irq_en` is set and the FIFO is non-empty.

## Operation
- **Input capture.** Each `sample_valid` captures `pressed = ~sample`.
  - If `pressed` equals the previous captured value, `stable_cnt` increments, saturating at 15.
  - Otherwise `stable_cnt` is set to 1.
  - When `stable_cnt` reaches `DEBOUNCE_SAMPLES`, `deb_state <= pressed`.
  - `chg = old deb_state ^ new deb_state` is loaded into `pending`.
- **Serialiser (states).**
  - `IDLE`: moves to `EMIT` when `pending` is non-zero.
  - `EMIT`: each cycle emits one event for the lowest set bit of `pending`, then clears that bit. Returns to `IDLE` when `pending` becomes zero.
- **Sample arriving while busy.** A `sample_valid` that arrives while in `EMIT` is ignored entirely: no capture and no counter update. It sets sticky `sample_lost`.
- **Event word (16 bits).**
  - [15:8] = `deb_state` snapshot.
  - [7] = 1 for press, 0 for release.
  - [6:3] = 0.
  - [2:0] = button index.
- **FIFO push.** A push while full drops the event and sets sticky `overflow`. When push and pop occur in the same cycle while full, both happen and the count is unchanged.
- **Register map.**
  - `PADDR` 0x00, read = STATUS:
    - [4:0] count
    - [8] empty
    - [9] full
    - [10] overflow
    - [11] sample_lost
    - [12] irq_en
  - `PADDR` 0x00, write = CTRL:
    - bit0 sets `irq_en`.
    - bit1 = 1 clears `overflow`.
    - bit2 = 1 clears `sample_lost`.
    - bit3 = 1 flushes the FIFO.
  - `PADDR` 0x04, read = POP:
    - [31] = valid, [15:0] = head event, other bits 0.
    - Pops when non-empty.
    - When empty, returns 0 and pops nothing.
  - `PADDR` 0x08, read = `{24'd0, deb_state}`.
  - Other addresses: reads return 0, writes are ignored.
- **Reset values.** `PRDATA` mux inputs all 0, `irq` = 0, `deb_state` = 0, `stable_cnt` = 0, `pending` = 0, FIFO empty, `overflow` = 0, `sample_lost` = 0, `irq_en` = 0, serialiser in `IDLE`.

## Timing
- **APB accesses.**
  - An access completes when `PSEL & PENABLE`; zero wait states.
  - A pop takes effect at the end of the access cycle.
  - A write takes effect on the `PCLK` edge ending the access.
- **Latencies.**
  - `sample_valid` (the debouncing sample) to first FIFO push: 2 cycles.
  - Subsequent events: one per cycle.
  - Push to `irq` high: 1 cycle.
- **Flush and push together.** A flush coinciding with a push leaves the FIFO empty; the flush wins.
- **Reset mid-stream.** `PRESET` in any state returns all registers to their reset values on the next edge. Any `pending` events are discarded.
- **Sample spacing.** The upstream block guarantees at least 18 cycles between strobes, so `sample_lost` only fires on abuse.

## Configuration
- Macro `NES_RELEASE_EVENTS_EN`.
- Defined: both press and release events are queued.
- Undefined:
  - Only press events are queued; release bits are cleared from `chg` before loading `pending`.
  - `deb_state` still tracks releases.

## Test plan
- **Debounce.** Reset, then 3 strobes of `sample` = 0x7F.
  - Expect `deb_state` = 0x80 after the 3rd strobe.
  - Expect POP = 0x8000_8087.
- **Glitch.** Strobes 0x7F, 0x7F, 0xFF, 0x7F.
  - Expect no event and `deb_state` = 0x00.
- **Multi-button.** 3 strobes of 0x7C.
  - Expect events on 3 consecutive cycles with indices 0, 1, 7.
  - Expect STATUS count = 3 and `irq` high when `irq_en` = 1.
- **Release.** With the macro defined, after the press above apply 3 strobes of 0xFF.
  - Expect release events 0x0000 (index 0), 0x0001, 0x0007, with bit 7 = 0.
  - With the macro undefined, expect no events.
- **Overflow.** Queue 9 events without popping.
  - Expect count = 8, full = 1, overflow = 1.
  - CTRL write 0x2 clears overflow.
  - Pop on empty returns 0x0000_0000.
- **Reset mid-EMIT.** Assert `PRESET` while `pending` = 0x81.
  - Expect FIFO empty, `irq` = 0, `deb_state` = 0 next cycle.

Source files
------------

// File: rtl/nes_button_events.sv
// rtl/nes_button_events.sv - debounced NES button state with a press/release event FIFO behind APB3
// Build option: define NES_RELEASE_EVENTS_EN to queue release events as well as presses.
module nes_button_events #(
    parameter int DEBOUNCE_SAMPLES = 3,
    parameter int FIFO_DEPTH       = 8
) (
    input  logic        PCLK,
    input  logic        PRESET,
    input  logic [7:0]  sample,
    input  logic        sample_valid,
    input  logic        PSEL,
    input  logic        PENABLE,
    input  logic        PWRITE,
    input  logic [7:0]  PADDR,
    input  logic [31:0] PWDATA,
    output logic [31:0] PRDATA,
    output logic        PREADY,
    output logic        PSLVERR,
    output logic        irq
);

    localparam int PTR_W = $clog2(FIFO_DEPTH);
    localparam int CNT_W = PTR_W + 1;

    localparam logic [7:0] ADDR_STATUS = 8'h00;
    localparam logic [7:0] ADDR_POP    = 8'h04;
    localparam logic [7:0] ADDR_STATE  = 8'h08;

    typedef enum logic {
        S_IDLE,
        S_EMIT
    } state_t;

    state_t state_q;
    state_t state_d;

    // Debounce / edge-detect state
    logic [7:0] prev_q;
    logic [7:0] deb_q;
    logic [7:0] pending_q;
    logic [3:0] stable_q;

    logic [7:0] pressed;
    logic [3:0] stable_d;
    logic [7:0] deb_d;
    logic [7:0] chg;
    logic [7:0] chg_queued;
    logic       capture;

    // Serialiser outputs
    logic        emit;
    logic [2:0]  emit_idx;
    logic [7:0]  emit_clear;
    logic [15:0] event_word;

    // FIFO state
    logic [15:0]      mem [FIFO_DEPTH];
    logic [PTR_W-1:0] wr_ptr_q;
    logic [PTR_W-1:0] rd_ptr_q;
    logic [CNT_W-1:0] count_q;
    logic [CNT_W-1:0] count_d;
    logic             fifo_empty;
    logic             fifo_full;
    logic             push_ok;
    logic             pop;

    // Control / status registers
    logic overflow_q;
    logic sample_lost_q;
    logic irq_en_q;
    logic irq_en_d;

    // APB decode
    logic apb_access;
    logic apb_wr;
    logic apb_rd;
    logic ctrl_wr;
    logic flush;
    logic [4:0] count5;

    logic unused_pwdata;

    assign PREADY        = 1'b1;
    assign PSLVERR       = 1'b0;
    assign unused_pwdata = ^PWDATA[31:4];

    assign apb_access = PSEL & PENABLE;
    assign apb_wr     = apb_access & PWRITE;
    assign apb_rd     = apb_access & ~PWRITE;
    assign ctrl_wr    = apb_wr && (PADDR == ADDR_STATUS);
    assign flush      = ctrl_wr && PWDATA[3];

    // Samples are only accepted while the serialiser is not draining a change set
    assign capture = sample_valid && (state_q == S_IDLE);
    assign pressed = ~sample;

    // Debounce counter and debounced-state candidate for the incoming sample
    always_comb begin
        stable_d = 4'd1;
        if (pressed == prev_q) begin
            stable_d = (stable_q == 4'd15) ? 4'd15 : stable_q + 4'd1;
        end
        deb_d = (stable_d == 4'(DEBOUNCE_SAMPLES)) ? pressed : deb_q;
        chg   = deb_q ^ deb_d;
`ifdef NES_RELEASE_EVENTS_EN
        chg_queued = chg;
`else
        chg_queued = chg & deb_d;
`endif
    end

    // Input capture registers: last raw sample, run length and debounced state
    always_ff @(posedge PCLK) begin
        if (PRESET) begin
            prev_q   <= 8'd0;
            stable_q <= 4'd0;
            deb_q    <= 8'd0;
        end else if (capture) begin
            prev_q   <= pressed;
            stable_q <= stable_d;
            deb_q    <= deb_d;
        end
    end

    // Serialiser state register
    always_ff @(posedge PCLK) begin
        if (PRESET) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Serialiser next state: emit lowest pending bit each cycle while in EMIT
    always_comb begin
        state_d  = state_q;
        emit     = 1'b0;
        emit_idx = 3'd0;
        for (int i = 7; i >= 0; i--) begin
            if (pending_q[i]) begin
                emit_idx = 3'(i);
            end
        end
        emit_clear = pending_q & ~(8'd1 << emit_idx);
        case (state_q)
            S_IDLE: begin
                if (pending_q != 8'd0) begin
                    state_d = S_EMIT;
                end
            end
            S_EMIT: begin
                emit = (pending_q != 8'd0);
                if (emit_clear == 8'd0) begin
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    assign event_word = {deb_q, deb_q[emit_idx], 4'd0, emit_idx};

    // Pending change set: loaded on capture (merged, never overwritten), drained by emit
    always_ff @(posedge PCLK) begin
        if (PRESET) begin
            pending_q <= 8'd0;
        end else if (capture) begin
            pending_q <= pending_q | chg_queued;
        end else if (emit) begin
            pending_q <= emit_clear;
        end
    end

    assign fifo_empty = (count_q == '0);
    assign fifo_full  = (count_q == CNT_W'(FIFO_DEPTH));
    assign pop        = apb_rd && (PADDR == ADDR_POP) && !fifo_empty;
    assign push_ok    = emit && (!fifo_full || pop);

    // Next FIFO occupancy; a flush overrides any simultaneous push or pop
    always_comb begin
        count_d = count_q;
        if (flush) begin
            count_d = '0;
        end else begin
            case ({push_ok, pop})
                2'b10:   count_d = count_q + CNT_W'(1);
                2'b01:   count_d = count_q - CNT_W'(1);
                default: count_d = count_q;
            endcase
        end
    end

    // FIFO storage write
    always_ff @(posedge PCLK) begin
        if (push_ok && !flush) begin
            mem[wr_ptr_q] <= event_word;
        end
    end

    // FIFO pointers and occupancy
    always_ff @(posedge PCLK) begin
        if (PRESET || flush) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (push_ok) begin
                wr_ptr_q <= wr_ptr_q + PTR_W'(1);
            end
            if (pop) begin
                rd_ptr_q <= rd_ptr_q + PTR_W'(1);
            end
            count_q <= count_d;
        end
    end

    assign irq_en_d = ctrl_wr ? PWDATA[0] : irq_en_q;

    // Sticky error flags, interrupt enable and registered interrupt output
    always_ff @(posedge PCLK) begin
        if (PRESET) begin
            overflow_q    <= 1'b0;
            sample_lost_q <= 1'b0;
            irq_en_q      <= 1'b0;
            irq           <= 1'b0;
        end else begin
            irq_en_q <= irq_en_d;
            irq      <= irq_en_d && (count_d != '0);
            if (emit && fifo_full && !pop) begin
                overflow_q <= 1'b1;
            end else if (ctrl_wr && PWDATA[1]) begin
                overflow_q <= 1'b0;
            end
            if (sample_valid && (state_q == S_EMIT)) begin
                sample_lost_q <= 1'b1;
            end else if (ctrl_wr && PWDATA[2]) begin
                sample_lost_q <= 1'b0;
            end
        end
    end

    assign count5 = 5'(count_q);

    // Read data mux from registered state
    always_comb begin
        PRDATA = 32'd0;
        case (PADDR)
            ADDR_STATUS: PRDATA = {19'd0, irq_en_q, sample_lost_q, overflow_q,
                                   fifo_full, fifo_empty, 3'd0, count5};
            ADDR_POP:    PRDATA = fifo_empty ? 32'd0 : {1'b1, 15'd0, mem[rd_ptr_q]};
            ADDR_STATE:  PRDATA = {24'd0, deb_q};
            default:     PRDATA = 32'd0;
        endcase
    end

endmodule

// File: tb/tb_nes_button_events.sv
// tb/tb_nes_button_events.sv - scoreboard bench for nes_button_events
module tb_nes_button_events;

    logic        PCLK;
    logic        PRESET;
    logic [7:0]  sample;
    logic        sample_valid;
    logic        PSEL;
    logic        PENABLE;
    logic        PWRITE;
    logic [7:0]  PADDR;
    logic [31:0] PWDATA;
    logic [31:0] PRDATA;
    logic        PREADY;
    logic        PSLVERR;
    logic        irq;

    nes_button_events dut (
        .PCLK        (PCLK),
        .PRESET      (PRESET),
        .sample      (sample),
        .sample_valid(sample_valid),
        .PSEL        (PSEL),
        .PENABLE     (PENABLE),
        .PWRITE      (PWRITE),
        .PADDR       (PADDR),
        .PWDATA      (PWDATA),
        .PRDATA      (PRDATA),
        .PREADY      (PREADY),
        .PSLVERR     (PSLVERR),
        .irq         (irq)
    );

    typedef struct {
        string       name;
        logic [31:0] val;
    } exp_t;

    exp_t exp_q[$];
    exp_t mon_e;
    int   checks = 0;
    int   errors = 0;

    initial PCLK = 1'b0;
    always #5 PCLK = ~PCLK;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    // Monitor: every completed APB read is matched against the next expected value
    always @(negedge PCLK) begin
        if (PSEL && PENABLE && !PWRITE) begin
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_read: got 0x%08h expected no read", PRDATA);
            end else begin
                mon_e = exp_q.pop_front();
                chk(mon_e.name, PRDATA, mon_e.val);
            end
        end
    end

    task automatic apb_read(input logic [7:0] addr, input logic [31:0] exp, input string name);
        exp_q.push_back('{name: name, val: exp});
        @(posedge PCLK); #1;
        PSEL = 1'b1; PENABLE = 1'b0; PWRITE = 1'b0; PADDR = addr;
        @(posedge PCLK); #1;
        PENABLE = 1'b1;
        @(posedge PCLK); #1;
        PSEL = 1'b0; PENABLE = 1'b0;
    endtask

    task automatic apb_write(input logic [7:0] addr, input logic [31:0] data);
        @(posedge PCLK); #1;
        PSEL = 1'b1; PENABLE = 1'b0; PWRITE = 1'b1; PADDR = addr; PWDATA = data;
        @(posedge PCLK); #1;
        PENABLE = 1'b1;
        @(posedge PCLK); #1;
        PSEL = 1'b0; PENABLE = 1'b0; PWRITE = 1'b0;
    endtask

    task automatic strobe(input logic [7:0] v);
        sample = v;
        sample_valid = 1'b1;
        @(posedge PCLK); #1;
        sample_valid = 1'b0;
    endtask

    task automatic idle(input int n);
        repeat (n) @(posedge PCLK);
        #1;
    endtask

    task automatic strobe3(input logic [7:0] v);
        for (int i = 0; i < 3; i++) begin
            strobe(v);
            idle(20);
        end
    endtask

    task automatic do_reset();
        PRESET = 1'b1;
        @(posedge PCLK); #1;
        PRESET = 1'b0;
    endtask

    initial begin
        PRESET = 1'b1; sample = 8'hFF; sample_valid = 1'b0;
        PSEL = 1'b0; PENABLE = 1'b0; PWRITE = 1'b0; PADDR = 8'h00; PWDATA = 32'd0;
        repeat (2) @(posedge PCLK);
        #1 PRESET = 1'b0;

        // Reset state
        chk("reset_irq", {31'd0, irq}, 32'd0);
        chk("pready", {31'd0, PREADY}, 32'd1);
        chk("pslverr", {31'd0, PSLVERR}, 32'd0);
        apb_read(8'h00, 32'h0000_0100, "reset_status");
        apb_read(8'h08, 32'h0000_0000, "reset_deb_state");
        apb_read(8'h04, 32'h0000_0000, "reset_pop_empty");
        apb_read(8'h0C, 32'h0000_0000, "unmapped_read");

        // Debounce: A pressed for 3 samples
        strobe(8'h7F); idle(20);
        strobe(8'h7F); idle(20);
        apb_read(8'h08, 32'h0000_0000, "deb_after_2");
        strobe(8'h7F); idle(20);
        apb_read(8'h08, 32'h0000_0080, "deb_after_3");
        apb_read(8'h00, 32'h0000_0001, "deb_status");
        apb_read(8'h04, 32'h8000_8087, "deb_pop");
        apb_read(8'h04, 32'h0000_0000, "deb_pop_empty");

        // Glitch breaks the run
        do_reset();
        strobe(8'h7F); idle(20);
        strobe(8'h7F); idle(20);
        strobe(8'hFF); idle(20);
        strobe(8'h7F); idle(20);
        apb_read(8'h08, 32'h0000_0000, "glitch_deb");
        apb_read(8'h00, 32'h0000_0100, "glitch_status");

        // Multi-button press with interrupt timing
        do_reset();
        apb_write(8'h00, 32'h1);
        apb_read(8'h00, 32'h0000_1100, "irq_en_status");
        strobe(8'h7C); idle(20);
        strobe(8'h7C); idle(20);
        strobe(8'h7C);
        fork
            begin
                @(posedge PCLK); #1;
                chk("irq_before_push", {31'd0, irq}, 32'd0);
                @(posedge PCLK); #1;
                chk("irq_after_push", {31'd0, irq}, 32'd1);
            end
            apb_read(8'h00, 32'h0000_1001, "multi_status_first");
        join
        apb_read(8'h00, 32'h0000_1003, "multi_status_all");
        chk("multi_irq_high", {31'd0, irq}, 32'd1);
        apb_read(8'h04, 32'h8000_8380, "multi_pop0");
        apb_read(8'h04, 32'h8000_8381, "multi_pop1");
        apb_read(8'h04, 32'h8000_8387, "multi_pop7");
        idle(2);
        chk("multi_irq_drained", {31'd0, irq}, 32'd0);

        // Release of the three buttons
        strobe3(8'hFF);
        apb_read(8'h08, 32'h0000_0000, "release_deb");
`ifdef NES_RELEASE_EVENTS_EN
        apb_read(8'h00, 32'h0000_1003, "release_status");
        apb_read(8'h04, 32'h8000_0000, "release_pop0");
        apb_read(8'h04, 32'h8000_0001, "release_pop1");
        apb_read(8'h04, 32'h8000_0007, "release_pop7");
`else
        apb_read(8'h00, 32'h0000_1100, "release_status");
        chk("release_irq_low", {31'd0, irq}, 32'd0);
`endif

        // Overflow: 8 presses, all released, then one more press
        do_reset();
        strobe3(8'h00);
        strobe3(8'hFF);
        strobe3(8'hFE);
        apb_read(8'h00, 32'h0000_0608, "ovf_status");
        apb_write(8'h00, 32'h2);
        apb_read(8'h00, 32'h0000_0208, "ovf_cleared");
        apb_read(8'h04, 32'h8000_FF80, "ovf_head");
        apb_read(8'h00, 32'h0000_0007, "ovf_after_pop");
        apb_write(8'h00, 32'h8);
        apb_read(8'h00, 32'h0000_0100, "flush_status");
        apb_read(8'h04, 32'h0000_0000, "flush_pop_empty");

        // Strobe arriving while serialiser busy
        do_reset();
        for (int i = 0; i < 5; i++) strobe(8'h00);
        idl_e: begin idle(20); end
        apb_read(8'h00, 32'h0000_0A08, "lost_status");
        apb_write(8'h00, 32'h4);
        apb_read(8'h00, 32'h0000_0208, "lost_cleared");
        apb_read(8'h08, 32'h0000_00FF, "lost_deb");

        // Reset while pending = 0x81
        do_reset();
        apb_write(8'h00, 32'h1);
        strobe(8'h7E); idle(20);
        strobe(8'h7E); idle(20);
        strobe(8'h7E);
        PRESET = 1'b1;
        @(posedge PCLK); #1;
        PRESET = 1'b0;
        chk("midemit_irq_next", {31'd0, irq}, 32'd0);
        idle(3);
        chk("midemit_irq_later", {31'd0, irq}, 32'd0);
        apb_read(8'h00, 32'h0000_0100, "midemit_status");
        apb_read(8'h08, 32'h0000_0000, "midemit_deb");
        apb_read(8'h04, 32'h0000_0000, "midemit_pop");

        idle(5);
        chk("scoreboard_drained", 32'(exp_q.size()), 32'd0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
